// File: rtl/alu_sequencer_pkg.sv
// Shared opcode map, FSM encoding and latency-lookup record for the ALU
// sequencer and the ALU it drives.
package alu_sequencer_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [OP_W-1:0] OP_OR   = 5'd3;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd4;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd9;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd10;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd11;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd12;

  localparam int              OP_COUNT = 13;
  localparam logic [OP_W-1:0] OP_LAST  = 5'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [CNT_W-1:0] latency;
    logic             err;
  } lat_info_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_latency_lut.sv
// Maps an opcode (and divisor) to the ALU settle latency and an error flag.
module alu_latency_lut
  import alu_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] b,
  output lat_info_t         info
);

  // Erroring requests get latency 0 so they reach RESP one cycle after accept.
  always_comb begin
    info.latency = 4'd1;
    info.err     = 1'b0;
    if (!op_is_legal(op)) begin
      info.latency = 4'd0;
      info.err     = 1'b1;
    end else if (op == OP_MUL) begin
      info.latency = CNT_W'(MUL_CYCLES);
    end else if (op == OP_DIV) begin
      if (b == '0) begin
        info.latency = 4'd0;
        info.err     = 1'b1;
      end else begin
        info.latency = CNT_W'(DIV_CYCLES);
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer: latches an operation onto an external ALU,
// waits the opcode's settle time, then presents the captured result.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [63:0]       alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [DATA_W-1:0] rsp_lo,
  output logic              rsp_err
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic              rsp_err_q, rsp_err_d;
  lat_info_t         lut_info;

  alu_latency_lut #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_lut (
    .op  (req_op),
    .b   (req_b),
    .info(lut_info)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_lo_d  = rsp_lo_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          alu_op_d = req_op;
          cnt_d    = lut_info.latency;
          err_d    = lut_info.err;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Counter parks at zero; an erroring request carries a zero result.
        if (cnt_q == '0) begin
          rsp_hi_d  = err_q ? '0 : alu_result[63:32];
          rsp_lo_d  = err_q ? '0 : alu_result[31:0];
          rsp_err_d = err_q;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_err   = rsp_err_q;

endmodule
